// File: rtl/dot_acc_2x36u.sv
// Sums two multiplier products per beat and accumulates them over last-delimited vectors into a 2-entry FWFT FIFO.
// Optional DOT_ACC_SATURATE_EN: clamp the accumulator to all-ones on overflow instead of wrapping.
module dot_acc_2x36u #(
    parameter int unsigned MUL_LATENCY = 4,
    parameter int unsigned IN_WIDTH    = 36,
    parameter int unsigned ACC_WIDTH   = 48
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  resulta,
    input  logic [IN_WIDTH-1:0]  resultb,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_ovf
);

    localparam int unsigned SUM_W = IN_WIDTH + 1;
    localparam int unsigned RAW_W = ACC_WIDTH + 1;
    // Capture stage plus MUL_LATENCY shifts, so a_valid coincides with resulta/resultb.
    localparam int unsigned DLY   = MUL_LATENCY + 1;

    typedef struct packed {
        logic                 ovf;
        logic [ACC_WIDTH-1:0] data;
    } entry_t;

    logic [DLY-1:0]       vld_sr;
    logic [DLY-1:0]       last_sr;
    logic                 accept_c;
    logic                 a_valid_c;
    logic                 a_last_c;

    logic [ACC_WIDTH-1:0] acc_q;
    logic                 ovf_q;
    logic                 first_q;
    logic [SUM_W-1:0]     sum_c;
    logic [RAW_W-1:0]     raw_c;
    logic                 ovf_next_c;
    logic [ACC_WIDTH-1:0] acc_next_c;

    logic [1:0]           rsv_q;
    logic [1:0]           rsv_next_c;

    entry_t               head_q;
    entry_t               tail_q;
    logic [1:0]           cnt_q;
    entry_t               head_next_c;
    entry_t               tail_next_c;
    logic [1:0]           cnt_next_c;
    entry_t               new_entry_c;
    logic                 push_c;
    logic                 pop_c;

    assign accept_c  = in_valid & in_ready;
    assign a_valid_c = vld_sr[DLY-1];
    assign a_last_c  = last_sr[DLY-1];

    // Valid/last delay line matching the multiplier pipeline.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            vld_sr  <= '0;
            last_sr <= '0;
        end else begin
            vld_sr  <= {vld_sr[DLY-2:0], accept_c};
            last_sr <= {last_sr[DLY-2:0], accept_c & in_last};
        end
    end

    // Per-beat sum and accumulator next value.
    always_comb begin
        sum_c      = SUM_W'(resulta) + SUM_W'(resultb);
        raw_c      = (first_q ? RAW_W'(0) : RAW_W'(acc_q)) + RAW_W'(sum_c);
        ovf_next_c = (first_q ? 1'b0 : ovf_q) | raw_c[ACC_WIDTH];
`ifdef DOT_ACC_SATURATE_EN
        acc_next_c = ovf_next_c ? '1 : raw_c[ACC_WIDTH-1:0];
`else
        acc_next_c = raw_c[ACC_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            first_q <= 1'b1;
        end else if (a_valid_c) begin
            acc_q   <= acc_next_c;
            ovf_q   <= ovf_next_c;
            first_q <= a_last_c;
        end
    end

    assign push_c = a_valid_c & a_last_c;
    assign pop_c  = out_valid & out_ready;

    // Reservation: one slot per accepted vector end, released on pop.
    always_comb begin
        rsv_next_c = rsv_q;
        if ((accept_c & in_last) & ~pop_c) begin
            rsv_next_c = rsv_q + 2'd1;
        end else if (~(accept_c & in_last) & pop_c) begin
            rsv_next_c = rsv_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rsv_q    <= 2'd0;
            in_ready <= 1'b1;
        end else begin
            rsv_q    <= rsv_next_c;
            in_ready <= (rsv_next_c < 2'd2);
        end
    end

    // Two-entry FIFO; head register drives the outputs directly.
    always_comb begin
        new_entry_c.ovf  = ovf_next_c;
        new_entry_c.data = acc_next_c;
        head_next_c      = head_q;
        tail_next_c      = tail_q;
        cnt_next_c       = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (push_c) begin
                    head_next_c = new_entry_c;
                    cnt_next_c  = 2'd1;
                end
            end
            2'd1: begin
                if (push_c && pop_c) begin
                    head_next_c = new_entry_c;
                end else if (pop_c) begin
                    cnt_next_c = 2'd0;
                end else if (push_c) begin
                    tail_next_c = new_entry_c;
                    cnt_next_c  = 2'd2;
                end
            end
            default: begin
                if (pop_c) begin
                    head_next_c = tail_q;
                    if (push_c) begin
                        tail_next_c = new_entry_c;
                    end else begin
                        cnt_next_c = 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= 2'd0;
            out_valid <= 1'b0;
        end else begin
            head_q    <= head_next_c;
            tail_q    <= tail_next_c;
            cnt_q     <= cnt_next_c;
            out_valid <= (cnt_next_c != 2'd0);
        end
    end

    assign out_data = head_q.data;
    assign out_ovf  = head_q.ovf;

endmodule

// File: tb/tb_dot_acc_2x36u.sv
// Scoreboard bench for dot_acc_2x36u: the bench plays the multiplier and checks results against vector totals.
module tb_dot_acc_2x36u;

    localparam int unsigned L  = 4;
    localparam int unsigned IW = 36;
    localparam int unsigned AW = 37;

    typedef logic [IW-1:0] prod_q_t[$];
    typedef struct packed {
        logic [AW-1:0] data;
        logic          ovf;
    } res_t;

    logic          clk = 1'b0;
    logic          arst;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [IW-1:0] resulta;
    logic [IW-1:0] resultb;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_data;
    logic          out_ovf;

    logic [IW-1:0] op_a;
    logic [IW-1:0] op_b;
    logic          rand_rdy = 1'b0;
    logic          rdy_force = 1'b1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int out_cnt = 0;
    res_t exp_q[$];
    logic [IW-1:0] sched_a[int];
    logic [IW-1:0] sched_b[int];

    dot_acc_2x36u #(
        .MUL_LATENCY(L),
        .IN_WIDTH(IW),
        .ACC_WIDTH(AW)
    ) dut (
        .clk(clk),
        .arst(arst),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_ready(in_ready),
        .resulta(resulta),
        .resultb(resultb),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Multiplier model: a product accepted at edge k is presented after edge k+L; also tracks outstanding results.
    initial begin
        resulta = '0;
        resultb = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (arst) begin
                sched_a.delete();
                sched_b.delete();
                out_cnt = 0;
            end else begin
                if (in_valid && in_ready) begin
                    sched_a[cyc + L] = op_a;
                    sched_b[cyc + L] = op_b;
                    if (in_last) out_cnt++;
                end
                if (out_valid && out_ready) out_cnt--;
            end
            #1;
            if (sched_a.exists(cyc)) begin
                resulta = sched_a[cyc];
                resultb = sched_b[cyc];
                sched_a.delete(cyc);
                sched_b.delete(cyc);
            end else begin
                resulta = IW'({$urandom, $urandom});
                resultb = IW'({$urandom, $urandom});
            end
        end
    end

    // Consumer ready: random in soak phase, otherwise follows rdy_force.
    always @(posedge clk) begin
        #2;
        out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    // Monitor: pops the scoreboard on every accepted output and checks hold/in_ready behaviour.
    logic          stall_prev = 1'b0;
    logic [AW-1:0] held_d;
    logic          held_o;
    res_t          e_m;
    always @(negedge clk) begin
        if (arst) begin
            stall_prev = 1'b0;
        end else begin
            chk("in_ready", 64'(in_ready), 64'(out_cnt < 2));
            if (stall_prev) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(held_d));
                chk("hold_ovf", 64'(out_ovf), 64'(held_o));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'(out_data), 64'hdead);
                end else begin
                    e_m = exp_q.pop_front();
                    chk("out_data", 64'(out_data), 64'(e_m.data));
                    chk("out_ovf", 64'(out_ovf), 64'(e_m.ovf));
                end
            end
            stall_prev = out_valid && !out_ready;
            held_d = out_data;
            held_o = out_ovf;
        end
    end

    task automatic beat(input logic [IW-1:0] a, input logic [IW-1:0] b, input logic last);
        int guard = 0;
        while (!in_ready) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 300) begin
                checks++;
                failures++;
                $display("FAIL in_ready_timeout: got 0 expected 1");
                return;
            end
        end
        in_valid = 1'b1;
        in_last  = last;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'($urandom);
        op_a     = IW'({$urandom, $urandom});
        op_b     = IW'({$urandom, $urandom});
    endtask

    task automatic send_vec(input prod_q_t av, input prod_q_t bv, input bit gaps);
        logic [63:0] tot = '0;
        res_t e;
        foreach (av[i]) tot += 64'(av[i]) + 64'(bv[i]);
        e.ovf = (tot >= (64'd1 << AW));
`ifdef DOT_ACC_SATURATE_EN
        e.data = e.ovf ? '1 : tot[AW-1:0];
`else
        e.data = tot[AW-1:0];
`endif
        exp_q.push_back(e);
        for (int i = 0; i < av.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            beat(av[i], bv[i], 1'(i == av.size() - 1));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] rnd_prod(input int mode);
        logic [63:0] r;
        r = {$urandom, $urandom};
        case (mode)
            0:       return IW'($urandom_range(0, 1000));
            1:       return '1;
            default: return r[IW-1:0];
        endcase
    endfunction

    initial begin
        prod_q_t av;
        prod_q_t bv;
        int g;
        arst     = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        op_a     = '0;
        op_b     = '0;
        idle(2);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        arst = 1'b0;
        idle(3);

        // Single-beat vector latency
        av = '{IW'(3)}; bv = '{IW'(5)};
        send_vec(av, bv, 1'b0);
        idle(L);
        chk("lat_not_early", 64'(out_valid), 64'd0);
        idle(1);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_data", 64'(out_data), 64'd8);
        idle(4);

        // Four-beat vector then a back-to-back vector
        av = '{IW'(1), IW'(3), IW'(5), IW'(7)}; bv = '{IW'(2), IW'(4), IW'(6), IW'(8)};
        send_vec(av, bv, 1'b0);
        av = '{IW'(100)}; bv = '{IW'(1)};
        send_vec(av, bv, 1'b0);
        av = '{IW'(2), IW'(3)}; bv = '{IW'(2), IW'(3)};
        send_vec(av, bv, 1'b0);
        idle(12);

        // Back-pressure
        rdy_force = 1'b0;
        av = '{IW'(1)}; bv = '{IW'(1)};
        send_vec(av, bv, 1'b0);
        av = '{IW'(2)}; bv = '{IW'(2)};
        send_vec(av, bv, 1'b0);
        idle(8);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_head", 64'(out_data), 64'd2);
        rdy_force = 1'b1;
        idle(1);
        rdy_force = 1'b0;
        chk("bp_in_ready_back", 64'(in_ready), 64'd1);
        chk("bp_next_head", 64'(out_data), 64'd4);
        av = '{IW'(3)}; bv = '{IW'(3)};
        send_vec(av, bv, 1'b0);
        rdy_force = 1'b1;
        idle(12);

        // Overflow
        av = '{'1, '1}; bv = '{'1, '1};
        send_vec(av, bv, 1'b0);
        av = '{'1, IW'(7), '1}; bv = '{IW'(0), IW'(0), IW'(1)};
        send_vec(av, bv, 1'b0);
        idle(12);

        // Reset mid-operation
        rdy_force = 1'b0;
        av = '{IW'(5)}; bv = '{IW'(5)};
        send_vec(av, bv, 1'b0);
        idle(7);
        av = '{IW'(1), IW'(2)}; bv = '{IW'(1), IW'(2)};
        send_vec(av, bv, 1'b0);
        arst = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_data", 64'(out_data), 64'd0);
        idle(1);
        arst = 1'b0;
        rdy_force = 1'b1;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            chk("no_stale", 64'(out_valid), 64'd0);
        end

        // Simultaneous push and pop
        rdy_force = 1'b0;
        av = '{IW'(10)}; bv = '{IW'(10)};
        send_vec(av, bv, 1'b0);
        g = 0;
        while (!out_valid && g < 20) begin
            idle(1);
            g++;
        end
        chk("pp_first_valid", 64'(out_valid), 64'd1);
        av = '{IW'(7)}; bv = '{IW'(0)};
        send_vec(av, bv, 1'b0);
        idle(L);
        rdy_force = 1'b1;
        idle(1);
        rdy_force = 1'b0;
        chk("pp_count_one", 64'(out_valid), 64'd1);
        chk("pp_head", 64'(out_data), 64'd7);
        rdy_force = 1'b1;
        idle(6);

        // Randomized soak
        rand_rdy = 1'b1;
        for (int v = 0; v < 60; v++) begin
            int n;
            int mode;
            av.delete();
            bv.delete();
            n = $urandom_range(1, 6);
            mode = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
                av.push_back(rnd_prod(mode));
                bv.push_back(rnd_prod(mode));
            end
            send_vec(av, bv, 1'b1);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        end
        rand_rdy = 1'b0;
        rdy_force = 1'b1;
        g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            idle(1);
            g++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        idle(3);
        chk("final_out_valid", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dot_acc_2x36u.md
Name: dot_acc_2x36u

Overview:
- Downstream consumer of the dual 18x18 unsigned multiplier stage (two products per clock, fixed pipeline latency, never stalls).
- Adds both products each beat and accumulates them over a vector delimited by a last flag, producing one dot-product result per vector.
- Delays the upstream valid/last internally so they line up with the multiplier outputs.
- Buffers results in a 2-entry output FIFO with valid/ready. Flow control is credit-based, because the multiplier pipeline cannot be back-pressured.

Parameters:
- MUL_LATENCY, 4, clock edges from multiplier operand capture to resulta/resultb valid; legal range 2..4.
- IN_WIDTH, 36, width of resulta and resultb.
- ACC_WIDTH, 48, accumulator and result width; must be >= IN_WIDTH+1.

Ports:
- clk  input  1  clock, rising edge.
- arst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands are presented to the multiplier this cycle.
- in_last  input  1  qualifies the final beat of a vector; ignored unless in_valid=1.
- in_ready  output  1  beat may be issued; upstream must not assert in_valid while in_ready=0.
- resulta  input  IN_WIDTH  product A from the multiplier.
- resultb  input  IN_WIDTH  product B from the multiplier.
- out_valid  output  1  FIFO head holds a completed dot product.
- out_ready  input  1  consumer accepts the FIFO head.
- out_data  output  ACC_WIDTH  dot product at the FIFO head.
- out_ovf  output  1  the head vector overflowed ACC_WIDTH at least once.

Behaviour:
- Reset: arst clears the valid/last delay line, accumulator, first flag (set to 1), FIFO (count 0), and reservation counter (0).
  - out_valid=0, out_data=0, out_ovf=0, in_ready=1 during and after reset.
  - Products already in flight in the multiplier are discarded, because their delayed valid is cleared.
- Accepted beat: in_valid & in_ready at a rising edge. Beats with in_valid & ~in_ready are an upstream protocol violation; the block drops them.
- Delay line: the accepted valid and last are shifted MUL_LATENCY stages. The outputs are a_valid and a_last, coincident with resulta/resultb for that beat.
- Per-beat sum: sum = resulta + resultb, IN_WIDTH+1 bits, zero-extended.
- Accumulator update, on an edge where a_valid=1:
  - acc_next = (first ? 0 : acc) + sum.
  - Overflow occurs on a carry out of ACC_WIDTH; acc wraps modulo 2^ACC_WIDTH.
  - ovf_next = (first ? 0 : ovf) | carry.
  - first <= a_last.
- Vector completion: when a_valid & a_last, {acc_next, ovf_next} is pushed into the FIFO at the same edge.
- Latency: a last beat accepted at edge E0 is written to the FIFO at edge E0+MUL_LATENCY+1.
  - With MUL_LATENCY=4 and an empty FIFO, out_valid rises 5 cycles after acceptance.
- Single-beat vector: in_last on the first beat gives out_data = resulta + resultb.
- Reservation counter (0..2):
  - +1 on an accepted beat with in_last=1.
  - -1 on a pop (out_valid & out_ready).
  - Unchanged when both happen in the same cycle.
  - in_ready = (reservation < 2). It is combinational from registered state only.
  - Guarantees a FIFO push never meets a full FIFO.
- FIFO: 2-entry, first-word-fall-through.
  - out_data/out_ovf come from the head; they are held stable while out_valid & ~out_ready.
  - A push and a pop in the same cycle are both honoured.
  - A push into an empty FIFO appears on out_valid the next cycle; there is no same-cycle bypass.
- Non-last beats are always accepted while in_ready=1. in_ready low blocks every beat, not just last beats, so vectors stay atomic.
- Reset mid-vector: the partial accumulation is lost; the next accepted beat starts a new vector.

Optional Feature:
- Macro: DOT_ACC_SATURATE_EN.
- Defined:
  - On carry, acc_next is forced to all-ones (2^ACC_WIDTH-1).
  - Subsequent beats of the same vector keep it at all-ones.
  - out_ovf still reports that saturation occurred.
- Undefined: wrap-around arithmetic as described above; out_ovf flags the wrap.

Test Plan:
- Single-beat vector, MUL_LATENCY=4: resulta=3, resultb=5, out_ready=1 → out_valid exactly 5 cycles after acceptance, out_data=8, out_ovf=0.
- 4-beat vector: products (1,2), (3,4), (5,6), (7,8) on consecutive cycles, last on beat 4 → out_data=36; a back-to-back following vector starts from 0.
- Back-pressure: out_ready=0; issue three 1-beat vectors → in_ready falls after the 2nd last is accepted; both results held in order; in_ready returns 1 the cycle after the first pop.
- Overflow: ACC_WIDTH=37; resulta=resultb=2^36-1 for 2 beats → out_ovf=1, out_data=(4*(2^36-1)) mod 2^37; with DOT_ACC_SATURATE_EN defined, out_data=2^37-1.
- Reset mid-operation: assert arst with 2 beats in flight and 1 FIFO entry → out_valid=0 and in_ready=1 immediately; no stale result appears in the following 10 cycles.
- Simultaneous push and pop: FIFO holding 1 entry, out_ready=1 while a new result completes → count stays 1, the results emerge in order, and no result is lost or duplicated.
